// File: rtl/ski_mem_arbiter.sv
// ski_mem_arbiter: round-robin front-end that shares one word heap between NCH reducer
// channels and returns per-channel tagged responses after a fixed RD_LAT pipeline.
// Optional build macro: HASKI_MEM_BOUNDS_CHECK_EN turns pointers >= DEPTH into tag-11
// responses that leave the heap untouched; without it the heap index wraps modulo DEPTH.
module ski_mem_arbiter #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned AW     = 30,
    parameter int unsigned DW     = 64,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic [NCH-1:0]    req_valid_i,
    input  logic [NCH-1:0]    req_write_i,
    input  logic [NCH*AW-1:0] req_ptr_i,
    input  logic [NCH*DW-1:0] req_data_i,
    output logic [NCH-1:0]    req_ready_o,
    output logic [2*NCH-1:0]  rsp_tag_o,
    output logic [NCH*DW-1:0] rsp_data_o,
    output logic              busy_o
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] TagRead  = 2'b01;
    localparam logic [1:0] TagWrite = 2'b10;
    localparam logic [1:0] TagError = 2'b11;

    logic [CW-1:0]    prio_q, prio_d;
    logic [NCH-1:0]   grant;
    logic             granted;
    logic [CW-1:0]    sel_ch;
    logic             sel_write;
    logic [AW-1:0]    sel_ptr;
    logic [DW-1:0]    sel_data;
    logic [IW-1:0]    sel_idx;
    logic             sel_oob;
    logic [1:0]       new_tag;
    logic [DW-1:0]    new_data;

    logic [DW-1:0]     heap_q [DEPTH];
    logic [RD_LAT-1:0] vld_q;
    logic [CW-1:0]     ch_q   [RD_LAT];
    logic [1:0]        tag_q  [RD_LAT];
    logic [DW-1:0]     data_q [RD_LAT];

    // Round-robin pick: first valid channel at or above the pointer, else first below it.
    always_comb begin
        grant   = '0;
        granted = 1'b0;
        sel_ch  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!granted && req_valid_i[k] && (CW'(k) >= prio_q)) begin
                granted  = 1'b1;
                grant[k] = 1'b1;
                sel_ch   = CW'(k);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (!granted && req_valid_i[k] && (CW'(k) < prio_q)) begin
                granted  = 1'b1;
                grant[k] = 1'b1;
                sel_ch   = CW'(k);
            end
        end
        // No handshakes while held in reset.
        if (!system1000_rstn) begin
            grant   = '0;
            granted = 1'b0;
        end
    end

    assign req_ready_o = grant;

    // Mux the granted channel's request fields.
    always_comb begin
        sel_write = 1'b0;
        sel_ptr   = '0;
        sel_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant[k]) begin
                sel_write = req_write_i[k];
                sel_ptr   = req_ptr_i[k*AW +: AW];
                sel_data  = req_data_i[k*DW +: DW];
            end
        end
    end

    assign sel_idx = sel_ptr[IW-1:0];

`ifdef HASKI_MEM_BOUNDS_CHECK_EN
    assign sel_oob = (64'(sel_ptr) >= 64'(DEPTH));
`else
    // Upper pointer bits are deliberately ignored so the index wraps.
    logic unused_ptr_hi;
    assign unused_ptr_hi = ^sel_ptr;
    assign sel_oob       = 1'b0;
`endif

    // Response word entering the pipeline for the granted request.
    always_comb begin
        new_tag  = sel_write ? TagWrite : TagRead;
        new_data = sel_write ? '0 : heap_q[sel_idx];
        if (sel_oob) begin
            new_tag  = TagError;
            new_data = '0;
        end
    end

    // Advance the priority pointer past the granted channel; hold it when idle.
    always_comb begin
        prio_d = prio_q;
        if (granted) begin
            prio_d = (sel_ch == CW'(NCH - 1)) ? '0 : sel_ch + 1'b1;
        end
    end

    // Heap write on the accept edge; contents survive reset.
    always_ff @(posedge system1000) begin
        if (granted && sel_write && !sel_oob) begin
            heap_q[sel_idx] <= sel_data;
        end
    end

    // Priority pointer and RD_LAT-deep response pipeline; reset drops in-flight entries.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            prio_q <= '0;
            vld_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                ch_q[i]   <= '0;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            prio_q    <= prio_d;
            vld_q[0]  <= granted;
            ch_q[0]   <= sel_ch;
            tag_q[0]  <= new_tag;
            data_q[0] <= new_data;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                ch_q[i]   <= ch_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Route the last pipeline stage onto its owning channel only.
    always_comb begin
        rsp_tag_o  = '0;
        rsp_data_o = '0;
        for (int k = 0; k < NCH; k++) begin
            if (vld_q[RD_LAT-1] && (ch_q[RD_LAT-1] == CW'(k))) begin
                rsp_tag_o[2*k +: 2]   = tag_q[RD_LAT-1];
                rsp_data_o[k*DW +: DW] = data_q[RD_LAT-1];
            end
        end
    end

    assign busy_o = |vld_q;

endmodule

// File: tb/tb_ski_mem_arbiter.sv
// Directed bench for ski_mem_arbiter: a round-robin/heap model pushes expected responses
// (with due cycle) into a scoreboard queue; every cycle checks ready, busy and all channels.
// Expected bounds behaviour follows HASKI_MEM_BOUNDS_CHECK_EN.
module tb_ski_mem_arbiter;

    localparam int unsigned NCH    = 4;
    localparam int unsigned AW     = 30;
    localparam int unsigned DW     = 64;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_write;
    logic [NCH*AW-1:0] req_ptr;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic [2*NCH-1:0]  rsp_tag;
    logic [NCH*DW-1:0] rsp_data;
    logic              busy;

    always #5 clk = ~clk;

    ski_mem_arbiter #(
        .NCH    (NCH),
        .AW     (AW),
        .DW     (DW),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .req_valid_i     (req_valid),
        .req_write_i     (req_write),
        .req_ptr_i       (req_ptr),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .rsp_tag_o       (rsp_tag),
        .rsp_data_o      (rsp_data),
        .busy_o          (busy)
    );

    typedef struct {
        int          due;
        int          ch;
        logic [1:0]  tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] mdl_mem [int];
    int            prio_m;
    int            ecount;
    int            errors;
    int            checks;
    bit            cont;
    bit            pend_v    [NCH];
    bit            pend_w    [NCH];
    logic [AW-1:0] pend_ptr  [NCH];
    logic [DW-1:0] pend_data [NCH];
    int            gcnt      [NCH];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic set_req(input int c, input bit w, input logic [AW-1:0] p,
                           input logic [DW-1:0] d);
        pend_v[c]    = 1'b1;
        pend_w[c]    = w;
        pend_ptr[c]  = p;
        pend_data[c] = d;
    endtask

    task automatic drive();
        for (int k = 0; k < NCH; k++) begin
            req_valid[k]           = pend_v[k];
            req_write[k]           = pend_w[k];
            req_ptr[k*AW +: AW]    = pend_ptr[k];
            req_data[k*DW +: DW]   = pend_data[k];
        end
    endtask

    function automatic int model_grant();
        if (!rstn) return -1;
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (prio_m + i) % NCH;
            if (pend_v[c]) return c;
        end
        return -1;
    endfunction

    // Model effect of an accept at the edge just counted in ecount.
    task automatic accept(input int c);
        exp_t e;
        int   idx;
        bit   oob;
        idx = int'(pend_ptr[c] % DEPTH);
        oob = 1'b0;
`ifdef HASKI_MEM_BOUNDS_CHECK_EN
        oob = (pend_ptr[c] >= DEPTH);
`endif
        e.due = ecount + RD_LAT - 1;
        e.ch  = c;
        if (oob) begin
            e.tag  = 2'b11;
            e.data = '0;
        end else if (pend_w[c]) begin
            mdl_mem[idx] = pend_data[c];
            e.tag  = 2'b10;
            e.data = '0;
        end else begin
            e.tag  = 2'b01;
            e.data = mdl_mem.exists(idx) ? mdl_mem[idx] : 'x;
        end
        sbq.push_back(e);
        prio_m    = (c + 1) % NCH;
        pend_v[c] = 1'b0;
        if (cont) begin
            if (pend_w[c]) set_req(c, 1'b0, pend_ptr[c], '0);
            else           set_req(c, 1'b1, pend_ptr[c], {$urandom, $urandom});
        end
    endtask

    // One clock: starts and ends just after a falling edge.
    task automatic cycle();
        int             g;
        logic [NCH-1:0] exp_rdy;
        exp_t           e;
        bit             hit;
        drive();
        #1;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", DW'(req_ready), DW'(exp_rdy));
        for (int k = 0; k < NCH; k++) gcnt[k] += int'(req_ready[k]);
        chk("busy", DW'(busy), DW'(sbq.size() != 0));
        e   = '{due: 0, ch: -1, tag: 2'b00, data: '0};
        hit = (sbq.size() != 0) && (sbq[0].due == ecount);
        if (hit) e = sbq.pop_front();
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("tag%0d@%0d", k, ecount), DW'(rsp_tag[2*k +: 2]),
                DW'((hit && e.ch == k) ? e.tag : 2'b00));
            chk($sformatf("data%0d@%0d", k, ecount), rsp_data[k*DW +: DW],
                (hit && e.ch == k) ? e.data : '0);
        end
        @(posedge clk);
        ecount++;
        if (g >= 0) accept(g);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit clear_pend);
        rstn = 1'b0;
        sbq.delete();
        prio_m = 0;
        if (clear_pend) for (int k = 0; k < NCH; k++) pend_v[k] = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        ecount = 0;
        prio_m = 0;
        cont   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            pend_v[k] = 1'b0; pend_w[k] = 1'b0; pend_ptr[k] = '0; pend_data[k] = '0;
            gcnt[k] = 0;
        end
        rstn = 1'b0;
        drive();
        @(negedge clk);

        // Reset with all channels requesting: no ready, idle outputs; ch0 first after release.
        for (int k = 0; k < NCH; k++) set_req(k, 1'b1, AW'(100 + k), 64'h1111_0000_0000_0000 + k);
        do_reset(1'b0);
        repeat (NCH + RD_LAT + 1) cycle();

        // Write then read the same word on back-to-back cycles.
        set_req(0, 1'b1, AW'(5), 64'hDEAD_BEEF_0000_0001);
        cycle();
        set_req(0, 1'b0, AW'(5), '0);
        repeat (RD_LAT + 2) cycle();

        // Fairness: all channels continuously requesting for 16 cycles.
        for (int k = 0; k < NCH; k++) begin
            set_req(k, 1'b1, AW'(200 + k), {$urandom, $urandom});
            gcnt[k] = 0;
        end
        cont = 1'b1;
        repeat (16) cycle();
        cont = 1'b0;
        for (int k = 0; k < NCH; k++) chk($sformatf("grants%0d", k), DW'(gcnt[k]), DW'(4));
        repeat (NCH + RD_LAT + 1) cycle();

        // Collision: ch0 writes and ch1 reads word 7 in the same cycle.
        set_req(0, 1'b1, AW'(7), 64'hC0FF_EE00_1234_5678);
        set_req(1, 1'b0, AW'(7), '0);
        repeat (2 + RD_LAT + 1) cycle();

        // Bounds: word 0 written, then pointer DEPTH read, then word 0 re-read.
        set_req(2, 1'b1, AW'(0), 64'hA5A5_5A5A_0F0F_F0F0);
        cycle();
        set_req(2, 1'b0, AW'(DEPTH), '0);
        cycle();
        set_req(2, 1'b0, AW'(0), '0);
        repeat (RD_LAT + 2) cycle();

        // Mid-flight reset drops both in-flight reads.
        set_req(0, 1'b0, AW'(5), '0);
        set_req(1, 1'b0, AW'(7), '0);
        cycle();
        cycle();
        do_reset(1'b1);
        repeat (4) cycle();

        // Heap contents survive reset.
        set_req(1, 1'b0, AW'(7), '0);
        repeat (RD_LAT + 2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
